axi_lite_regfile_slave: RTL and testbench

AXI4-Lite responder with a bank of NUM_REGS read/write registers. It connects to the single slave-side port of `axi_lite_arbiter` and terminates the write and read transactions that the arbiter forwards. The AW and W channels are accepted independently, committed as one write, and answered on B. Reads return registered data on R.

---
 rtl/axi_lite_regfile_slave.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile_slave.sv
`timescale 1ns/1ps
// AXI4-Lite register bank: B rises one edge after AW and W are both held, R rises one edge after AR.
// The AW/W holding slots and the R slot keep their readies low until the pending B/R is accepted.
module axi_lite_regfile_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_s_axi_awvalid,
  output logic                    o_s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   i_s_axi_awaddr,
  input  logic [2:0]              i_s_axi_awprot,
  input  logic                    i_s_axi_wvalid,
  output logic                    o_s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   i_s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_s_axi_wstrb,
  output logic                    o_s_axi_bvalid,
  input  logic                    i_s_axi_bready,
  output logic [1:0]              o_s_axi_bresp,
  input  logic                    i_s_axi_arvalid,
  output logic                    o_s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   i_s_axi_araddr,
  input  logic [2:0]              i_s_axi_arprot,
  output logic                    o_s_axi_rvalid,
  input  logic                    i_s_axi_rready,
  output logic [DATA_WIDTH-1:0]   o_s_axi_rdata,
  output logic [1:0]              o_s_axi_rresp
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(STRB);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  rst_done_q;
  logic                  aw_full_q, aw_full_d;
  logic                  aw_ok_q, aw_ok_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB-1:0]       w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                  aw_ok, ar_ok;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  unused_prot;

  assign unused_prot = ^{i_s_axi_awprot, i_s_axi_arprot};

  // Word index after removing the base; the byte-lane bits fall off in the shift.
  assign aw_word = (i_s_axi_awaddr - BASE_ADDR) >> LSB;
  assign ar_word = (i_s_axi_araddr - BASE_ADDR) >> LSB;
  assign aw_ok   = (i_s_axi_awaddr >= BASE_ADDR) && (aw_word < NREG);
  assign ar_ok   = (i_s_axi_araddr >= BASE_ADDR) && (ar_word < NREG);
  assign aw_idx  = aw_word[IDX_W-1:0];
  assign ar_idx  = ar_word[IDX_W-1:0];

  assign o_s_axi_awready = ~aw_full_q & rst_done_q;
  assign o_s_axi_wready  = ~w_full_q & rst_done_q;
  assign o_s_axi_arready = ~rvalid_q & rst_done_q;
  assign o_s_axi_bvalid  = bvalid_q;
  assign o_s_axi_bresp   = bresp_q;
  assign o_s_axi_rvalid  = rvalid_q;
  assign o_s_axi_rdata   = rdata_q;
  assign o_s_axi_rresp   = rresp_q;

  assign aw_hs  = i_s_axi_awvalid & o_s_axi_awready;
  assign w_hs   = i_s_axi_wvalid & o_s_axi_wready;
  assign ar_hs  = i_s_axi_arvalid & o_s_axi_arready;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_ok_d   = aw_ok_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    if (bvalid_q && i_s_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
      if (aw_ok_q) begin
        for (int k = 0; k < STRB; k++) begin
          if (w_strb_q[k]) regs_d[aw_idx_q][8*k +: 8] = w_data_q[8*k +: 8];
        end
      end
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_ok_d   = aw_ok;
      aw_idx_d  = aw_idx;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = i_s_axi_wdata;
      w_strb_d = i_s_axi_wstrb;
    end

    if (rvalid_q && i_s_axi_rready) rvalid_d = 1'b0;
    // Reads sample regs_q, so a same-edge commit is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? regs_q[ar_idx] : '0;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_ok_q    <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      regs_q     <= '{default: '0};
    end else begin
      rst_done_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_ok_q    <= aw_ok_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
`timescale 1ns/1ps
// Bench for axi_lite_regfile_slave: directed scenarios plus random traffic against a word-array model.
module tb_axi_lite_regfile_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  axi_lite_regfile_slave dut (
    .clk(clk), .resetn(resetn),
    .i_s_axi_awvalid(awvalid), .o_s_axi_awready(awready), .i_s_axi_awaddr(awaddr), .i_s_axi_awprot(awprot),
    .i_s_axi_wvalid(wvalid), .o_s_axi_wready(wready), .i_s_axi_wdata(wdata), .i_s_axi_wstrb(wstrb),
    .o_s_axi_bvalid(bvalid), .i_s_axi_bready(bready), .o_s_axi_bresp(bresp),
    .i_s_axi_arvalid(arvalid), .o_s_axi_arready(arready), .i_s_axi_araddr(araddr), .i_s_axi_arprot(arprot),
    .o_s_axi_rvalid(rvalid), .i_s_axi_rready(rready), .o_s_axi_rdata(rdata), .o_s_axi_rresp(rresp)
  );

  // Reference: 16 words at byte 0..63; anything else is an error and touches nothing.
  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return in_rng(a) ? model[a / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    if (in_rng(a)) model[a / 4] = (model[a / 4] & ~m) | (d & m);
  endtask

  // AW and W raised after their own delays; lat counts edges from the last handshake to bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int adly, input int wdly, output logic [1:0] resp, output int lat);
    int n;
    bit ad, wd, ah, wh;
    n = 0; ad = 0; wd = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(ad && wd) && n < 40) begin
      awvalid = !ad && (n >= adly);
      wvalid  = !wd && (n >= wdly);
      ah = awvalid & awready;
      wh = wvalid & wready;
      @(posedge clk); #1;
      n++;
      if (ah) ad = 1;
      if (wh) wd = 1;
    end
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (!bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    resp = bresp;
    bready = 1; @(posedge clk); #1; bready = 0;
  endtask

  // lat counts extra edges after the AR handshake edge before rvalid is seen.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    arvalid = 1; araddr = a;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    d = rdata; resp = rresp;
    rready = 1; @(posedge clk); #1; rready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}); end
    resetn = 1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL ready_before_first_edge: got %b expected 000", {awready, wready, arready}); end
    @(posedge clk); #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_after_first_edge: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b expected 00", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_b_latency: got %0d expected 1", lat); end
    do_read(32'h4, d, r, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h expected deadbeef", d); end
    checks++; if ({r, lat[3:0]} !== 6'b00_0000) begin errors++; $display("FAIL basic_rresp_lat: got resp %b lat %0d expected 00 0", r, lat); end
  endtask

  task automatic test_split();
    logic [1:0] r; logic [31:0] d; int lat;
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({awready, wready, bvalid} !== 3'b100) begin errors++; $display("FAIL split_hold_%0d: got aw/w/b %b expected 100", i, {awready, wready, bvalid}); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    awaddr = 32'h4; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    checks++; if ({awready, wready, bvalid} !== 3'b000) begin errors++; $display("FAIL split_both_held: got aw/w/b %b expected 000", {awready, wready, bvalid}); end
    @(posedge clk); #1;
    checks++; if ({bvalid, bresp, awready, wready} !== 5'b10011) begin errors++; $display("FAIL split_commit: got bvalid/bresp/aw/w %b expected 10011", {bvalid, bresp, awready, wready}); end
    bready = 1; @(posedge clk); #1; bready = 0;
    model_write(32'h4, 32'h11223344, 4'b0101);
    do_read(32'h4, d, r, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL split_rdata: got %h expected de22be44", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 1, r, lat);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b expected 10", r); end
    do_read(32'h40, d, r, lat);
    checks++; if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL oor_read: got %h/%b expected 0/10", d, r); end
    do_write(32'h3C, 32'h0BADCAFE, 4'hF, 1, 0, r, lat);
    model_write(32'h3C, 32'h0BADCAFE, 4'hF);
    do_read(32'h3F, d, r, lat);
    checks++; if ({d, r} !== {model[15], 2'b00}) begin errors++; $display("FAIL last_reg_read: got %h/%b expected %h/00", d, r, model[15]); end
    do_read(32'h0, d, r, lat);
    checks++; if (d !== model[0]) begin errors++; $display("FAIL oor_no_side_effect: got %h expected %h", d, model[0]); end
  endtask

  task automatic test_backpressure_b();
    logic [31:0] v;
    v = $urandom;
    awaddr = 32'h8; wdata = v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL bp_first_b: got %b expected 100", {bvalid, bresp}); end
    model_write(32'h8, v, 4'hF);
    awaddr = 32'h80; wdata = $urandom; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({awready, wready, bvalid, bresp} !== 5'b00100) begin errors++; $display("FAIL bp_stall_%0d: got aw/w/bvalid/bresp %b expected 00100", i, {awready, wready, bvalid, bresp}); end
      @(posedge clk); #1;
    end
    bready = 1; @(posedge clk); #1; bready = 0;
    checks++; if ({bvalid, awready, wready} !== 3'b000) begin errors++; $display("FAIL bp_after_accept: got b/aw/w %b expected 000", {bvalid, awready, wready}); end
    @(posedge clk); #1;
    checks++; if ({bvalid, bresp, awready, wready} !== 5'b11011) begin errors++; $display("FAIL bp_second_b: got %b expected 11011", {bvalid, bresp, awready, wready}); end
    bready = 1; @(posedge clk); #1; bready = 0;
  endtask

  task automatic test_backpressure_r();
    logic [31:0] e;
    e = exp_read(32'h8);
    arvalid = 1; araddr = 32'h8;
    @(posedge clk); #1;
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({arready, rvalid, rresp, rdata} !== {1'b0, 1'b1, 2'b00, e}) begin errors++; $display("FAIL rbp_hold_%0d: got ar/rv %b rdata %h expected 01 %h", i, {arready, rvalid}, rdata, e); end
      @(posedge clk); #1;
    end
    rready = 1; @(posedge clk); #1; rready = 0;
    checks++; if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL rbp_release: got ar/rv %b expected 10", {arready, rvalid}); end
  endtask

  task automatic test_collision();
    logic [31:0] old, nd, d; logic [1:0] r; int lat;
    old = model[3]; nd = $urandom;
    awaddr = 32'hC; wdata = nd; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'hC;
    @(posedge clk); #1;
    arvalid = 0;
    checks++; if ({rvalid, bvalid, rdata} !== {2'b11, old}) begin errors++; $display("FAIL collision_old_data: got rv/bv %b rdata %h expected 11 %h", {rvalid, bvalid}, rdata, old); end
    bready = 1; rready = 1; @(posedge clk); #1; bready = 0; rready = 0;
    model_write(32'hC, nd, 4'hF);
    do_read(32'hC, d, r, lat);
    checks++; if (d !== nd) begin errors++; $display("FAIL collision_new_data: got %h expected %h", d, nd); end
  endtask

  task automatic test_three_masters();
    logic [31:0] vals [3];
    logic [1:0] r; logic [31:0] d; int lat, nb;
    vals[0] = 32'hDEADBEEF; vals[1] = 32'hABCDFFFF; vals[2] = 32'hFFFFFFFF;
    nb = 0;
    for (int m = 0; m < 3; m++) begin
      do_write(32'(m * 4), vals[m], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), r, lat);
      if (lat < 20 && r === 2'b00) nb++;
      model_write(32'(m * 4), vals[m], 4'hF);
    end
    checks++; if (nb !== 3) begin errors++; $display("FAIL masters_b_count: got %0d expected 3", nb); end
    for (int m = 0; m < 3; m++) begin
      do_read(32'(m * 4), d, r, lat);
      checks++; if (d !== vals[m]) begin errors++; $display("FAIL masters_readback_%0d: got %h expected %h", m, d, vals[m]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, v, d; logic [3:0] s; logic [1:0] r; int lat;
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
        checks++; if ({r, lat[4:0]} !== {exp_resp(a), 5'd1}) begin errors++; $display("FAIL rand_write_%0d: addr %h got resp %b lat %0d expected %b 1", i, a, r, lat, exp_resp(a)); end
        model_write(a, v, s);
      end else begin
        do_read(a, d, r, lat);
        checks++; if ({d, r, lat[4:0]} !== {exp_read(a), exp_resp(a), 5'd0}) begin errors++; $display("FAIL rand_read_%0d: addr %h got %h/%b lat %0d expected %h/%b 0", i, a, d, r, lat, exp_read(a), exp_resp(a)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; int lat;
    awaddr = 32'h4; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    arvalid = 1; araddr = 32'h4;
    @(posedge clk); #1;
    arvalid = 0;
    checks++; if ({awready, rvalid} !== 2'b01) begin errors++; $display("FAIL midrst_setup: got aw/rv %b expected 01", {awready, rvalid}); end
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    checks++; if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}); end
    @(posedge clk); #1;
    checks++; if ({awready, wready, arready, bvalid} !== 4'b1110) begin errors++; $display("FAIL midrst_readies: got %b expected 1110", {awready, wready, arready, bvalid}); end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), d, r, lat);
      checks++; if ({d, r} !== {model[i], 2'b00}) begin errors++; $display("FAIL midrst_reg_%0d: got %h/%b expected %h/00", i, d, r, model[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_basic();
    test_split();
    test_out_of_range();
    test_backpressure_b();
    test_backpressure_r();
    test_collision();
    test_three_masters();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
